// File: rtl/ibex_rvfi_trace_ctrl.sv
// rtl/ibex_rvfi_trace_ctrl.sv - RVFI retirement capture, record FIFO and 3-beat trace drain
// Gates retirements via start/stop/PC trigger and never back-pressures the core (drops instead).
module ibex_rvfi_trace_ctrl #(
  parameter int Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rvfi_valid_i,
  input  logic [63:0]                rvfi_order_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic                       rvfi_trap_i,
  input  logic                       rvfi_intr_i,
  input  logic                       cfg_start_i,
  input  logic                       cfg_stop_i,
  input  logic                       cfg_clear_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_data_o,
  output logic                       trace_last_o,
  output logic                       capturing_o,
  output logic                       armed_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_cnt_o,
  output logic [$clog2(Depth):0]     fifo_level_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t            state, state_next;
  logic              push_req, push_ok, drop, hs, pop;
  logic [81:0]       mem [Depth];
  logic [81:0]       rec, head;
  logic [PtrW-1:0]   wptr, rptr;
  logic [LvlW-1:0]   level;
  logic [1:0]        beat;
  logic [31:0]       beat_word;
  logic              unused_order;

  assign unused_order = ^rvfi_order_i[63:16];

  // Record layout: order[81:66], trap[65], intr[64], pc[63:32], insn[31:0]
  assign rec  = {rvfi_order_i[15:0], rvfi_trap_i, rvfi_intr_i, rvfi_pc_rdata_i, rvfi_insn_i};
  assign head = mem[rptr];

  always_comb begin
    state_next = state;
    push_req   = 1'b0;
    if (cfg_stop_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start_i) state_next = trig_en_i ? ARMED : CAPTURE;
        end
        ARMED: begin
          if (rvfi_valid_i && (rvfi_pc_rdata_i == trig_pc_i)) begin
            push_req   = 1'b1;
            state_next = CAPTURE;
          end
        end
        CAPTURE: push_req = rvfi_valid_i;
        default: state_next = IDLE;
      endcase
    end
  end

  assign trace_valid_o = (level != '0);
  assign hs            = trace_valid_o && trace_ready_i;
  assign pop           = hs && (beat == 2'd2);
  // A full FIFO still accepts when the head leaves on this same edge.
  assign push_ok       = push_req && ((level != LvlFull) || pop);
  assign drop          = push_req && !push_ok;

  always_comb begin
    beat_word = '0;
    case (beat)
      2'd0:    beat_word = {8'hA5, 6'b0, head[65], head[64], head[81:66]};
      2'd1:    beat_word = head[63:32];
      2'd2:    beat_word = head[31:0];
      default: beat_word = '0;
    endcase
  end

  assign trace_data_o = trace_valid_o ? beat_word : '0;
  assign trace_last_o = trace_valid_o && (beat == 2'd2);
  assign capturing_o  = (state == CAPTURE);
  assign armed_o      = (state == ARMED);
  assign fifo_level_o = level;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= rec;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      beat       <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      state <= state_next;
      level <= level + LvlW'(push_ok) - LvlW'(pop);
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (hs)      beat <= (beat == 2'd2) ? 2'd0 : beat + 2'd1;
      // A drop coinciding with clear counts as the first drop after clear.
      if (cfg_clear_i) begin
        overflow_o <= drop;
        drop_cnt_o <= {7'b0, drop};
      end else if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_rvfi_trace_ctrl.sv
// tb/tb_ibex_rvfi_trace_ctrl.sv - directed and random checks of ibex_rvfi_trace_ctrl against a queue model
module tb_ibex_rvfi_trace_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [63:0] order = '0;
  logic [31:0] pc = '0;
  logic [31:0] insn = '0;
  logic        trap = 1'b0;
  logic        intr = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        ready = 1'b0;
  logic        t_valid, t_last, capturing, armed, overflow;
  logic [31:0] t_data;
  logic [7:0]  drop_cnt;
  logic [3:0]  level;

  int tests = 0;
  int fails = 0;

  logic [81:0] mq[$];
  int          mbeat = 0;
  int          mstate = 0;
  bit          mover = 0;
  int          mdrops = 0;

  ibex_rvfi_trace_ctrl #(.Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rvfi_valid_i(valid), .rvfi_order_i(order), .rvfi_pc_rdata_i(pc),
    .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr),
    .cfg_start_i(start), .cfg_stop_i(stop), .cfg_clear_i(clear),
    .trig_en_i(trig_en), .trig_pc_i(trig_pc),
    .trace_valid_o(t_valid), .trace_ready_i(ready), .trace_data_o(t_data),
    .trace_last_o(t_last), .capturing_o(capturing), .armed_o(armed),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt), .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [81:0] r, input int b);
    logic [15:0] o;
    o = r[81:66];
    if (b == 0) return {8'hA5, 6'b0, r[65], r[64], o};
    if (b == 1) return r[63:32];
    return r[31:0];
  endfunction

  // Compare against the model at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit hs, pop, push, drop;
    int ns;
    @(negedge clk);
    chk("valid", t_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("data", t_data, word_of(mq[0], mbeat));
      chk("last", t_last, mbeat == 2);
    end
    chk("capturing", capturing, mstate == 2);
    chk("armed", armed, mstate == 1);
    chk("overflow", overflow, mover);
    chk("drop_cnt", drop_cnt, mdrops);
    chk("level", level, mq.size());
    hs = (mq.size() != 0) && ready;
    pop = hs && (mbeat == 2);
    push = 0;
    ns = mstate;
    if (stop) ns = 0;
    else if (mstate == 0) begin
      if (start) ns = trig_en ? 1 : 2;
    end else if (mstate == 1) begin
      if (valid && pc == trig_pc) begin push = 1; ns = 2; end
    end else push = valid;
    if (hs) mbeat = (mbeat + 1) % 3;
    if (pop) void'(mq.pop_front());
    drop = 0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back({order[15:0], trap, intr, pc, insn});
      else drop = 1;
    end
    if (clear) begin
      mover = drop;
      mdrops = drop ? 1 : 0;
    end else if (drop) begin
      mover = 1;
      if (mdrops < 255) mdrops++;
    end
    mstate = ns;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields(input logic [31:0] p);
    pc = p;
    insn = $urandom;
    order = {$urandom, 16'h0, 16'($urandom)};
    trap = 1'($urandom);
    intr = 1'($urandom);
  endtask

  task automatic retire(input logic [31:0] p);
    rand_fields(p);
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic pulse_start(input logic te);
    trig_en = te;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic drain();
    int n;
    ready = 1'b1;
    n = 0;
    while (mq.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_done", mq.size(), 0);
  endtask

  initial begin
    logic [31:0] held;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", t_valid, 0);
    chk("rst_data", t_data, 0);
    chk("rst_last", t_last, 0);
    chk("rst_cap", capturing, 0);
    chk("rst_armed", armed, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_cnt, 0);
    chk("rst_level", level, 0);

    // Single record, full-rate drain
    ready = 1'b1;
    pulse_start(1'b0);
    pc = 32'h100; insn = 32'h13; order = 64'd5; trap = 0; intr = 0;
    valid = 1'b1; step(); valid = 1'b0;
    chk("beat0", t_data, 32'hA5000005);
    chk("beat0_last", t_last, 0);
    step();
    chk("beat1", t_data, 32'h100);
    chk("beat1_last", t_last, 0);
    step();
    chk("beat2", t_data, 32'h13);
    chk("beat2_last", t_last, 1);
    step();
    chk("empty_after", t_valid, 0);

    // PC trigger
    pulse_stop();
    ready = 1'b0;
    trig_pc = 32'h200;
    pulse_start(1'b1);
    chk("armed_set", armed, 1);
    retire(32'h1FC);
    chk("still_armed", armed, 1);
    chk("no_rec_1fc", level, 0);
    retire(32'h200);
    chk("cap_after_trig", capturing, 1);
    retire(32'h204);
    chk("trig_level", level, 2);
    drain();

    // Overflow and clear
    pulse_stop();
    ready = 1'b0;
    pulse_start(1'b0);
    repeat (10) retire($urandom);
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_cnt, 2);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_flag", overflow, 0);
    chk("clr_drops", drop_cnt, 0);
    chk("clr_level", level, 8);

    // Full FIFO with beat 2 leaving while a retirement arrives
    ready = 1'b1;
    step();
    step();
    retire($urandom);
    chk("full_pop_level", level, 8);
    chk("full_pop_drops", drop_cnt, 0);
    chk("full_pop_ovf", overflow, 0);

    // Saturation, then clear coincident with a drop
    ready = 1'b0;
    repeat (300) retire($urandom);
    chk("sat_drops", drop_cnt, 255);
    clear = 1'b1;
    retire($urandom);
    clear = 1'b0;
    chk("clr_drop_ovf", overflow, 1);
    chk("clr_drop_cnt", drop_cnt, 1);

    // Start and stop together in IDLE
    pulse_stop();
    start = 1'b1; stop = 1'b1; trig_en = 1'b0; step(); start = 1'b0; stop = 1'b0;
    chk("ss_cap", capturing, 0);
    chk("ss_armed", armed, 0);

    // Random traffic
    drain();
    for (int i = 0; i < 600; i++) begin
      ready = ($urandom_range(0, 9) < 6);
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 29) == 0);
      trig_en = 1'($urandom);
      if ($urandom_range(0, 49) == 0) trig_pc = {$urandom_range(0, 3), 2'b00};
      rand_fields(($urandom_range(0, 3) == 0) ? trig_pc : {$urandom_range(0, 7), 2'b00});
      valid = 1'($urandom);
      step();
    end
    start = 0; stop = 0; clear = 0; valid = 0;

    // Stall mid-record, then reset mid-record
    drain();
    pulse_stop();
    pulse_start(1'b0);
    retire(32'h300);
    step();
    chk("stall_at_beat1", mbeat, 1);
    ready = 1'b0;
    held = t_data;
    repeat (5) begin
      step();
      chk("stall_stable", t_data, held);
    end
    chk("stall_data", held, 32'h300);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", t_valid, 0);
    chk("arst_level", level, 0);
    mq.delete(); mbeat = 0; mstate = 0; mover = 0; mdrops = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
